dma_cfg_master: RTL

AXI-lite write initiator that programs the DMA register slave on behalf of a host-side controller. On a single start pulse it issues four ordered register writes (source, destination, size, control/start) over the address, write-data and write-response channels, waits for each response, and reports completion or error. It sits between the system control logic and the DMA register block's slave port.

---
 rtl/dma_cfg_pkg.sv | 15 +
 rtl/dma_cfg_master.sv | 106 ++++++++++
 2 files changed

// File: rtl/dma_cfg_pkg.sv
// dma_cfg_pkg: register map, start-bit constant and FSM encoding for the DMA config master
package dma_cfg_pkg;
  localparam logic [31:0] REG_SRC = 32'h0;
  localparam logic [31:0] REG_DST = 32'h4;
  localparam logic [31:0] REG_SIZE = 32'h8;
  localparam logic [31:0] REG_CTRL = 32'hC;
  localparam logic [31:0] CTRL_START = 32'h0000_0001;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, DONE} state_t;
  function automatic logic [31:0] reg_off(input logic [1:0] k);
    return k == 2'd0 ? REG_SRC : k == 2'd1 ? REG_DST : k == 2'd2 ? REG_SIZE : REG_CTRL;
  endfunction
  function automatic logic [31:0] reg_data(input logic [1:0] k, input logic [31:0] src, dst, size);
    return k == 2'd0 ? src : k == 2'd1 ? dst : k == 2'd2 ? size : CTRL_START;
  endfunction
endpackage

// File: rtl/dma_cfg_master.sv
// dma_cfg_master: issues the four ordered AXI-lite register writes that program and start the DMA
import dma_cfg_pkg::*;
module dma_cfg_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_src,
  input  logic [31:0] cfg_dst,
  input  logic [31:0] cfg_size,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [31:0] m_addr,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] k, k_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] src, dst, size, src_n, dst_n, size_n, addr_n, wdata_n;
  logic valid_n, wvalid_n, bready_n, busy_n, done_n, err_n;
  logic timeout, issue_ok;
  assign timeout = cnt == TO_LAST;
  // a channel counts as finished once its valid has dropped or is handshaking now
  assign issue_ok = (!m_valid || m_ready) && (!m_wvalid || m_wready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      {src, dst, size, m_addr, m_wdata} <= '0;
      {m_valid, m_wvalid, m_bready, cfg_busy, cfg_done, cfg_err} <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      cnt <= cnt_n;
      {src, dst, size, m_addr, m_wdata} <= {src_n, dst_n, size_n, addr_n, wdata_n};
      {m_valid, m_wvalid, m_bready, cfg_busy, cfg_done, cfg_err} <= {valid_n, wvalid_n, bready_n, busy_n, done_n, err_n};
    end
  end
  always_comb begin
    state_n = state;
    k_n = k;
    cnt_n = (state == ISSUE || state == WAIT_B) ? cnt + 16'd1 : cnt;
    {src_n, dst_n, size_n, addr_n, wdata_n} = {src, dst, size, m_addr, m_wdata};
    {valid_n, wvalid_n, bready_n, busy_n, done_n, err_n} = {m_valid, m_wvalid, m_bready, cfg_busy, cfg_done, cfg_err};
    case (state)
      IDLE: if (cfg_start) begin
        {src_n, dst_n, size_n} = {cfg_src, cfg_dst, cfg_size};
        k_n = 2'd0;
        cnt_n = '0;
        busy_n = 1'b1;
        err_n = cfg_size == 32'd0;
        state_n = cfg_size == 32'd0 ? DONE : ISSUE;
        addr_n = BASE_ADDR + reg_off(2'd0);
        wdata_n = cfg_src;
        valid_n = cfg_size != 32'd0;
        wvalid_n = cfg_size != 32'd0;
      end
      ISSUE: begin
        valid_n = m_valid && !m_ready;
        wvalid_n = m_wvalid && !m_wready;
        if (issue_ok) begin
          bready_n = 1'b1;
          state_n = WAIT_B;
        end else if (timeout) begin
          {valid_n, wvalid_n} = 2'b00;
          {err_n, done_n} = 2'b11;
          state_n = DONE;
        end
      end
      WAIT_B: if (m_bvalid && m_bready) begin
        bready_n = 1'b0;
        done_n = k == 2'd3;
        state_n = k == 2'd3 ? DONE : ISSUE;
        if (k != 2'd3) begin
          k_n = k + 2'd1;
          cnt_n = '0;
          addr_n = BASE_ADDR + reg_off(k + 2'd1);
          wdata_n = reg_data(k + 2'd1, src, dst, size);
          {valid_n, wvalid_n} = 2'b11;
        end
      end else if (timeout) begin
        bready_n = 1'b0;
        {err_n, done_n} = 2'b11;
        state_n = DONE;
      end
      // a zero-size reject enters with done low and spends one extra cycle here
      DONE: begin
        done_n = !cfg_done;
        busy_n = !cfg_done;
        state_n = cfg_done ? IDLE : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
